// File: rtl/i2s_tx.sv
// i2s_tx: single-entry sample buffer feeding an I2S serializer.
// Bit clock and word select are derived from clk_i by integer division;
// every accepted mono sample is played on both channels of one frame.
module i2s_tx #(
  parameter int width_p      = 12,
  parameter int slot_width_p = 16,
  parameter int clk_div_p    = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               bclk_o,
  output logic               lrclk_o,
  output logic               sdata_o,
  output logic               underflow_o
);

  localparam int div_w_lp = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
  localparam int pos_w_lp = (slot_width_p > 1) ? $clog2(2 * slot_width_p) : 1;

  localparam logic [div_w_lp-1:0] div_last_lp  = div_w_lp'(clk_div_p - 1);
  localparam logic [pos_w_lp-1:0] pos_last_lp  = pos_w_lp'(2 * slot_width_p - 1);
  localparam logic [pos_w_lp-1:0] slot_lp      = pos_w_lp'(slot_width_p);
  localparam logic [pos_w_lp-1:0] slot_last_lp = pos_w_lp'(slot_width_p - 1);

  // Slot bit idx of a sample: bit 0 is the MSB, bits past the sample width are zero.
  function automatic logic slot_bit(input logic [width_p-1:0] frame,
                                    input logic [pos_w_lp-1:0] idx);
    logic bit_v;
    bit_v = 1'b0;
    for (int i = 0; i < width_p; i++) begin
      bit_v = (idx == pos_w_lp'(i)) ? frame[width_p-1-i] : bit_v;
    end
    return bit_v;
  endfunction

  logic [div_w_lp-1:0] div_cnt_r;
  logic                bclk_r;
  logic [pos_w_lp-1:0] pos_r;
  logic                lrclk_r;
  logic                sdata_r;
  logic                underflow_r;
  logic                ready_r;
  logic [width_p-1:0]  hold_r;
  logic                hold_valid_r;
  logic [width_p-1:0]  frame_r;

  logic                div_wrap_s;
  logic                fall_s;
  logic                load_s;
  logic                accept_s;
  logic [pos_w_lp-1:0] pos_nxt_s;
  logic [pos_w_lp-1:0] slot_pos_s;
  logic [width_p-1:0]  frame_nxt_s;
  logic                hold_valid_nxt_s;
  logic                sdata_nxt_s;
  logic                lrclk_nxt_s;

  assign div_wrap_s = (div_cnt_r == div_last_lp);
  assign fall_s     = div_wrap_s & bclk_r;
  assign accept_s   = valid_i & ready_r;
  assign load_s     = fall_s & (pos_nxt_s == pos_w_lp'(1));

  // Next frame position: advances on each bclk falling edge, wraps at the frame end.
  always_comb begin
    pos_nxt_s = pos_r;
    if (fall_s) begin
      if (pos_r == pos_last_lp) begin
        pos_nxt_s = pos_w_lp'(0);
      end else begin
        pos_nxt_s = pos_r + pos_w_lp'(1);
      end
    end else begin
      pos_nxt_s = pos_r;
    end
  end

  // Frame register and holding-register handoff at the start of each frame.
  always_comb begin
    frame_nxt_s      = frame_r;
    hold_valid_nxt_s = hold_valid_r;
    if (load_s) begin
      if (hold_valid_r) begin
        frame_nxt_s = hold_r;
      end else begin
        frame_nxt_s = {width_p{1'b0}};
      end
    end else begin
      frame_nxt_s = frame_r;
    end
    if (load_s && hold_valid_r) begin
      hold_valid_nxt_s = 1'b0;
    end else if (accept_s) begin
      hold_valid_nxt_s = 1'b1;
    end else begin
      hold_valid_nxt_s = hold_valid_r;
    end
  end

  // Serial bit for the next position, one bclk behind the slot boundary.
  always_comb begin
    slot_pos_s  = pos_nxt_s;
    sdata_nxt_s = 1'b0;
    lrclk_nxt_s = (pos_nxt_s >= slot_lp);
    if (pos_nxt_s >= slot_lp) begin
      slot_pos_s = pos_nxt_s - slot_lp;
    end else begin
      slot_pos_s = pos_nxt_s;
    end
    if (slot_pos_s == pos_w_lp'(0)) begin
      sdata_nxt_s = slot_bit(frame_nxt_s, slot_last_lp);
    end else begin
      sdata_nxt_s = slot_bit(frame_nxt_s, slot_pos_s - pos_w_lp'(1));
    end
  end

  // Bit-clock divider and frame position counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_r <= div_w_lp'(0);
      bclk_r    <= 1'b0;
      pos_r     <= pos_w_lp'(0);
    end else begin
      div_cnt_r <= div_wrap_s ? div_w_lp'(0) : div_cnt_r + div_w_lp'(1);
      bclk_r    <= div_wrap_s ? ~bclk_r : bclk_r;
      pos_r     <= pos_nxt_s;
    end
  end

  // Sample buffering: holding register, frame register and handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_r       <= {width_p{1'b0}};
      hold_valid_r <= 1'b0;
      frame_r      <= {width_p{1'b0}};
      ready_r      <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      hold_r       <= accept_s ? data_i : hold_r;
      hold_valid_r <= hold_valid_nxt_s;
      frame_r      <= frame_nxt_s;
      ready_r      <= ~hold_valid_nxt_s;
      underflow_r  <= load_s & ~hold_valid_r;
    end
  end

  // Word select and serial data change only on bclk falling edges.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lrclk_r <= 1'b0;
      sdata_r <= 1'b0;
    end else if (fall_s) begin
      lrclk_r <= lrclk_nxt_s;
      sdata_r <= sdata_nxt_s;
    end else begin
      lrclk_r <= lrclk_r;
      sdata_r <= sdata_r;
    end
  end

  assign ready_o     = ready_r;
  assign bclk_o      = bclk_r;
  assign lrclk_o     = lrclk_r;
  assign sdata_o     = sdata_r;
  assign underflow_o = underflow_r;

endmodule
